sprite_eval: RTL and testbench
==============================

Name: sprite_eval

Overview:
- Per-scanline sprite evaluation stage. Scans the 64-entry primary OAM (256 bytes) and collects up to 8 sprites whose Y range covers the target scanline into an 8-slot secondary buffer.
- The slot outputs (row/col/table_num/attr per slot) feed sprite_priority_decode directly. The stage also raises the PPU status sprite-overflow flag and a sprite-0-present flag.
- Runs once per scanline, triggered by the PPU timing controller during the visible line.

Parameters:
- NUM_SPRITES, 64, primary OAM entries scanned (4 bytes each).
- NUM_SLOTS, 8, secondary slots; fixed at 8 for downstream compatibility.

Ports:
- clk  input  1  PPU clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse; begins evaluation; ignored unless IDLE.
- target_row  input  9  scanline being evaluated (0..239); sampled on accepted start.
- ppu_ctrl_1  input  8  bit 5 selects sprite height (0 = 8 lines, 1 = 16 lines); sampled on accepted start.
- oam_addr  output  8  registered OAM read address.
- oam_data  input  8  OAM read data; valid the cycle after oam_addr is driven (1-cycle latency).
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  one-cycle pulse when evaluation completes.
- slot_row  output  64  slot n Y byte at [8n+7:8n].
- slot_col  output  64  slot n X byte.
- slot_table_num  output  64  slot n tile index.
- slot_attr  output  64  slot n attribute byte.
- slot_valid  output  8  bit n set when slot n holds a found sprite.
- sprite_overflow  output  1  a 9th in-range sprite was found.
- sprite0_present  output  1  OAM sprite 0 occupies slot 0.

Behaviour:
- Reset (async):
  - State goes to IDLE; oam_addr = 0; busy = 0; done = 0.
  - All slot bytes = 8'hFF; slot_valid = 0; sprite_overflow = 0; sprite0_present = 0.
- FSM states: IDLE, CLEAR, REQ_Y, CHK_Y, REQ_B, CAP_B, DONE.
- IDLE:
  - On start, latch target_row and height, set busy, go to CLEAR.
  - Outputs hold the previous results.
- CLEAR (1 cycle):
  - All slots = 8'hFF; slot_valid, overflow and sprite0 flags = 0.
  - Sprite index n = 0; slot count c = 0; go to REQ_Y.
- REQ_Y: oam_addr <= 4n; go to CHK_Y.
- CHK_Y:
  - Compute d = {2'b0,target_row} - {3'b0,oam_data} in 11 bits.
  - The sprite is in range iff d >= 0 and d < height.
  - In range with c < 8: store Y in slot c; if n == 0, set sprite0_present; byte index k = 1; go to REQ_B.
  - In range with c == 8: set sprite_overflow and go to DONE. The scan stops.
  - Not in range: n++; if n == NUM_SPRITES go to DONE, else go to REQ_Y.
- REQ_B: oam_addr <= 4n + k; go to CAP_B.
- CAP_B:
  - Store oam_data into slot c: k=1 tile, k=2 attr, k=3 col.
  - If k < 3: k++ and go to REQ_B.
  - If k == 3: set slot_valid[c], c++, n++; go to DONE if n == NUM_SPRITES, else REQ_Y.
- DONE (1 cycle): done = 1, busy = 0, then IDLE.
- Cycle counts:
  - Out-of-range sprite: 2 cycles. In-range sprite: 8 cycles.
  - Worst case: 1 + 8*8 + 56*2 + 1 = 178 cycles after start.
- Slot fill order: slots fill in ascending OAM index, so slot 0 is the highest priority.
- Unfilled slots stay at 8'hFF with slot_valid = 0.
- Arithmetic: no wrap-around. A Y of 0xEF..0xFF never matches scanlines below Y.
- Overflow uses a correct Y check (no hardware diagonal-scan bug).
- Results (slots, flags) are stable from done until the next accepted start's CLEAR cycle.
- A start pulse while busy is ignored and target_row is not re-sampled.
- Reset mid-scan aborts immediately and no done pulse is emitted.
- oam_addr is 8 bits; 4n+3 never exceeds 255 for NUM_SPRITES = 64.

Test Plan:
- Reset, then start with target_row=10 and OAM all 0xFF -> done at cycle 130; slot_valid=0; all slots 0xFF; overflow=0.
- OAM sprite 0 = {Y=5, tile=0x12, attr=0x40, X=0x30}, rest Y=0xFF; target_row=12; ctrl_1[5]=0 -> slot0 = {05,12,40,30}; slot_valid=8'h01; sprite0_present=1.
- Same OAM, target_row=13 -> d=8, so not in range; slot_valid=0. With ctrl_1[5]=1 -> in range; slot_valid=8'h01.
- Sprites 3..12 all Y=20, target_row=20 -> slots 0..7 hold sprites 3..10; slot_valid=8'hFF; overflow=1; sprite0_present=0; done 1 cycle after CHK_Y of sprite 11.
- Second start pulse mid-scan -> ignored; results are those of the first target_row.
- Assert rst at cycle 40 of a scan -> slots revert to 0xFF and busy=0 asynchronously; no done; a subsequent start evaluates normally.

Source files
------------

// File: rtl/sprite_eval.sv
// sprite_eval: per-scanline sprite evaluation. Walks primary OAM, copies up
// to NUM_SLOTS in-range sprites into secondary slots, flags overflow/sprite 0.
module sprite_eval #(
  parameter int NUM_SPRITES = 64,
  parameter int NUM_SLOTS   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [8:0]             target_row,
  input  logic [7:0]             ppu_ctrl_1,
  output logic [7:0]             oam_addr,
  input  logic [7:0]             oam_data,
  output logic                   busy,
  output logic                   done,
  output logic [8*NUM_SLOTS-1:0] slot_row,
  output logic [8*NUM_SLOTS-1:0] slot_col,
  output logic [8*NUM_SLOTS-1:0] slot_table_num,
  output logic [8*NUM_SLOTS-1:0] slot_attr,
  output logic [NUM_SLOTS-1:0]   slot_valid,
  output logic                   sprite_overflow,
  output logic                   sprite0_present
);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_REQ_Y, S_CHK_Y, S_REQ_B, S_CAP_B, S_DONE} state_t;

  state_t state;
  logic [8:0] row_q;
  logic       tall_q;
  logic [6:0] n;     // OAM sprite index
  logic [3:0] c;     // slots filled so far (0..NUM_SLOTS)
  logic [1:0] k;     // byte within the sprite being copied
  logic [NUM_SLOTS-1:0][7:0] row_s, col_s, tbl_s, attr_s;

  logic [10:0] d;
  logic        hit;
  logic        last;

  assign slot_row       = row_s;
  assign slot_col       = col_s;
  assign slot_table_num = tbl_s;
  assign slot_attr      = attr_s;

  // Y range test: widened subtraction so sprites below the line never wrap into range.
  always_comb begin
    d    = {2'b0, row_q} - {3'b0, oam_data};
    hit  = !d[10] && (d < (tall_q ? 11'd16 : 11'd8));
    last = (n == 7'(NUM_SPRITES - 1));
  end

  // Evaluation FSM; every output is registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      oam_addr        <= 8'd0;
      busy            <= 1'b0;
      done            <= 1'b0;
      row_q           <= 9'd0;
      tall_q          <= 1'b0;
      n               <= 7'd0;
      c               <= 4'd0;
      k               <= 2'd0;
      row_s           <= '1;
      col_s           <= '1;
      tbl_s           <= '1;
      attr_s          <= '1;
      slot_valid      <= '0;
      sprite_overflow <= 1'b0;
      sprite0_present <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            row_q  <= target_row;
            tall_q <= ppu_ctrl_1[5];
            busy   <= 1'b1;
            state  <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          row_s           <= '1;
          col_s           <= '1;
          tbl_s           <= '1;
          attr_s          <= '1;
          slot_valid      <= '0;
          sprite_overflow <= 1'b0;
          sprite0_present <= 1'b0;
          n               <= 7'd0;
          c               <= 4'd0;
          state           <= S_REQ_Y;
        end
        S_REQ_Y: begin
          oam_addr <= {n[5:0], 2'b00};
          state    <= S_CHK_Y;
        end
        S_CHK_Y: begin
          if (hit) begin
            if (c == 4'(NUM_SLOTS)) begin
              // ninth hit: flag it and stop scanning
              sprite_overflow <= 1'b1;
              busy            <= 1'b0;
              done            <= 1'b1;
              state           <= S_DONE;
            end else begin
              row_s[c[2:0]] <= oam_data;
              if (n == 7'd0) sprite0_present <= 1'b1;
              k     <= 2'd1;
              state <= S_REQ_B;
            end
          end else begin
            n <= n + 7'd1;
            if (last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_REQ_Y;
            end
          end
        end
        S_REQ_B: begin
          oam_addr <= {n[5:0], k};
          state    <= S_CAP_B;
        end
        S_CAP_B: begin
          case (k)
            2'd1:    tbl_s[c[2:0]]  <= oam_data;
            2'd2:    attr_s[c[2:0]] <= oam_data;
            default: col_s[c[2:0]]  <= oam_data;
          endcase
          if (k != 2'd3) begin
            k     <= k + 2'd1;
            state <= S_REQ_B;
          end else begin
            slot_valid[c[2:0]] <= 1'b1;
            c <= c + 4'd1;
            n <= n + 7'd1;
            if (last) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_REQ_Y;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_eval.sv
// tb_sprite_eval: directed + randomized scans of an OAM array, checked
// against a plain-arithmetic model of the sprite selection rules.
module tb_sprite_eval;

  logic        clk, rst, start;
  logic [8:0]  target_row;
  logic [7:0]  ppu_ctrl_1;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_data;
  logic        busy, done;
  logic [63:0] slot_row, slot_col, slot_table_num, slot_attr;
  logic [7:0]  slot_valid;
  logic        sprite_overflow, sprite0_present;

  logic [7:0] oam [256];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc;

  logic [63:0] er, ec, et, ea;
  logic [7:0]  ev;
  bit          eo, es;
  int          ecyc;

  sprite_eval dut (
    .clk(clk), .rst(rst), .start(start), .target_row(target_row),
    .ppu_ctrl_1(ppu_ctrl_1), .oam_addr(oam_addr), .oam_data(oam_data),
    .busy(busy), .done(done), .slot_row(slot_row), .slot_col(slot_col),
    .slot_table_num(slot_table_num), .slot_attr(slot_attr),
    .slot_valid(slot_valid), .sprite_overflow(sprite_overflow),
    .sprite0_present(sprite0_present)
  );

  assign oam_data = oam[oam_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: walk sprites in OAM order, keep the first 8 whose line offset is
  // in [0, height), note a 9th hit, and total up the cycle cost of the scan.
  task automatic model(input int row, input bit tall);
    int cnt, h, y, diff;
    er = '1; ec = '1; et = '1; ea = '1; ev = '0; eo = 0; es = 0;
    cnt = 0; h = tall ? 16 : 8; ecyc = 1;
    for (int s = 0; s < 64; s++) begin
      y = int'(oam[4*s]);
      diff = row - y;
      if (diff >= 0 && diff < h) begin
        if (cnt == 8) begin
          eo = 1; ecyc += 2; break;
        end
        er[8*cnt +: 8] = oam[4*s];
        et[8*cnt +: 8] = oam[4*s+1];
        ea[8*cnt +: 8] = oam[4*s+2];
        ec[8*cnt +: 8] = oam[4*s+3];
        ev[cnt] = 1'b1;
        if (s == 0) es = 1;
        cnt++;
        ecyc += 8;
      end else begin
        ecyc += 2;
      end
    end
    ecyc += 1;
  endtask

  task automatic step();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic start_scan(input logic [8:0] row, input bit tall);
    @(negedge clk);
    target_row = row; ppu_ctrl_1 = {2'b00, tall, 5'b0}; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cyc = 1;
  endtask

  task automatic wait_done();
    while (!done && cyc < 400) step();
    chk("done_seen", done, 1'b1);
  endtask

  task automatic check_results(input string tag);
    chk({tag, "_cycles"}, cyc, ecyc);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_row"}, slot_row, er);
    chk({tag, "_col"}, slot_col, ec);
    chk({tag, "_tbl"}, slot_table_num, et);
    chk({tag, "_attr"}, slot_attr, ea);
    chk({tag, "_valid"}, slot_valid, ev);
    chk({tag, "_ovf"}, sprite_overflow, eo);
    chk({tag, "_s0"}, sprite0_present, es);
    step();
    chk({tag, "_hold_valid"}, slot_valid, ev);
    chk({tag, "_hold_row"}, slot_row, er);
    chk({tag, "_done_pulse"}, done, 1'b0);
  endtask

  task automatic scan(input string tag, input logic [8:0] row, input bit tall);
    model(int'(row), tall);
    start_scan(row, tall);
    chk({tag, "_busy_start"}, busy, 1'b1);
    wait_done();
    check_results(tag);
  endtask

  task automatic fill_random(input int row);
    int y;
    for (int s = 0; s < 64; s++) begin
      y = int'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0 && row >= 16) y = row - int'($urandom_range(0, 16));
      oam[4*s]   = 8'(y);
      oam[4*s+1] = 8'($urandom);
      oam[4*s+2] = 8'($urandom);
      oam[4*s+3] = 8'($urandom);
    end
  endtask

  initial begin
    logic [8:0] r;
    bit t;
    rst = 1'b1; start = 1'b0; target_row = '0; ppu_ctrl_1 = '0; cyc = 0;
    for (int i = 0; i < 256; i++) oam[i] = 8'hFF;
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_addr", oam_addr, 8'h00);
    chk("rst_row", slot_row, {64{1'b1}});
    chk("rst_col", slot_col, {64{1'b1}});
    chk("rst_valid", slot_valid, 8'h00);
    chk("rst_ovf", sprite_overflow, 1'b0);
    chk("rst_s0", sprite0_present, 1'b0);
    @(negedge clk); rst = 1'b0;

    // empty OAM: pure scan length, no hits, no wrap from Y=0xFF
    scan("empty", 9'd10, 1'b0);
    chk("empty_len", ecyc, 130);

    // single sprite 0 at Y=5
    oam[0] = 8'h05; oam[1] = 8'h12; oam[2] = 8'h40; oam[3] = 8'h30;
    scan("spr0", 9'd12, 1'b0);
    chk("spr0_tile_lit", slot_table_num[7:0], 8'h12);
    scan("spr0_off", 9'd13, 1'b0);
    chk("spr0_off_lit", slot_valid, 8'h00);
    scan("spr0_tall", 9'd13, 1'b1);
    chk("spr0_tall_lit", slot_valid, 8'h01);
    scan("spr0_above", 9'd4, 1'b1);

    // ten sprites on one line: eight fill, the ninth flags overflow
    for (int i = 0; i < 256; i++) oam[i] = 8'hFF;
    for (int s = 3; s <= 12; s++) begin
      oam[4*s] = 8'd20; oam[4*s+1] = 8'(s); oam[4*s+2] = 8'(s + 8'h10); oam[4*s+3] = 8'(s + 8'h20);
    end
    scan("ovf", 9'd20, 1'b0);
    chk("ovf_len", ecyc, 74);
    chk("ovf_lit", sprite_overflow, 1'b1);

    // randomized OAM contents and scanlines
    for (int it = 0; it < 8; it++) begin
      r = 9'($urandom_range(0, 239));
      t = 1'($urandom_range(0, 1));
      fill_random(int'(r));
      scan("rand", r, t);
    end

    // second start mid-scan must not re-sample target_row
    fill_random(100);
    model(100, 1'b0);
    start_scan(9'd100, 1'b0);
    repeat (19) step();
    @(negedge clk); target_row = 9'd200; ppu_ctrl_1 = 8'h20; start = 1'b1;
    step();
    start = 1'b0;
    wait_done();
    check_results("restart");

    // reset at cycle 40 aborts the scan
    fill_random(150);
    start_scan(9'd150, 1'b0);
    repeat (39) step();
    #2 rst = 1'b1;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_row", slot_row, {64{1'b1}});
    chk("abort_valid", slot_valid, 8'h00);
    chk("abort_ovf", sprite_overflow, 1'b0);
    @(negedge clk); rst = 1'b0;
    begin
      bit saw_done;
      saw_done = 0;
      repeat (200) begin
        step();
        if (done) saw_done = 1;
      end
      chk("abort_no_done", saw_done, 1'b0);
    end
    scan("post_abort", 9'd150, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
